mips_multicycle_control: RTL and testbench

Multi-cycle main control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALU's 4-bit operation code (the initiator side of the ALU interface) and consumes the ALU `Zero` flag for branch resolution. It sits between the instruction register and every datapath mux and write enable.

---
 rtl/mips_pkg.sv | 36 +++
 rtl/mips_alu_op_decode.sv | 42 ++++
 rtl/mips_multicycle_control.sv | 140 ++++++++++++++
 tb/tb_mips_multicycle_control.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multi-cycle MIPS control path.
package mips_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_REXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP
    } state_e;
    typedef enum logic [1:0] {CLS_ADDR, CLS_REXEC, CLS_IEXEC, CLS_BRANCH} alu_cls_e;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_NOR   = 4'b0010;
    localparam logic [3:0] ALU_ADD   = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_SHIFT = 4'b1110;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/mips_alu_op_decode.sv
// mips_alu_op_decode: ALU operation select per state class, plus instruction legality.
module mips_alu_op_decode
    import mips_pkg::*;
(
    input  alu_cls_e    cls,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_op,
    output logic        legal
);
    logic [3:0] r_op;
    logic       r_ok;
    logic [3:0] i_op;
    always_comb begin
        r_op = ALU_ADD;
        r_ok = 1'b1;
        case (funct)
            FN_ADD:  r_op = ALU_ADD;
            FN_SUB:  r_op = ALU_SUB;
            FN_AND:  r_op = ALU_AND;
            FN_OR:   r_op = ALU_OR;
            FN_NOR:  r_op = ALU_NOR;
            FN_SLL:  r_op = ALU_SHIFT;
            default: r_ok = 1'b0;
        endcase
    end
    always_comb begin
        i_op = (opcode == OP_ANDI) ? ALU_AND :
               (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
        alu_op = (cls == CLS_REXEC)  ? r_op :
                 (cls == CLS_IEXEC)  ? i_op :
                 (cls == CLS_BRANCH) ? ALU_SUB : ALU_ADD;
    end
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: legal = r_ok;
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: main control FSM sequencing each MIPS instruction
// through fetch, decode, execute, memory and writeback.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOperation,
    output logic       InstrDone,
    output logic       IllegalOp
);
    state_e   state_q, state_d;
    alu_cls_e cls;
    logic     legal;
    logic     take_branch;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;

    always_comb begin
        cls = (state_q == S_REXEC)  ? CLS_REXEC  :
              (state_q == S_IEXEC)  ? CLS_IEXEC  :
              (state_q == S_BRANCH) ? CLS_BRANCH : CLS_ADDR;
        take_branch = ((Opcode == OP_BEQ) & Zero) | ((Opcode == OP_BNE) & ~Zero);
    end

    mips_alu_op_decode u_alu_op_decode (
        .cls    (cls),
        .opcode (Opcode),
        .funct  (Funct),
        .alu_op (ALUOperation),
        .legal  (legal)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:
                if (!legal)                                     state_d = S_FETCH;
                else if (Opcode == OP_LW || Opcode == OP_SW)    state_d = S_MEMADDR;
                else if (Opcode == OP_RTYPE)                    state_d = S_REXEC;
                else if (Opcode == OP_BEQ || Opcode == OP_BNE)  state_d = S_BRANCH;
                else if (Opcode == OP_J)                        state_d = S_JUMP;
                else                                            state_d = S_IEXEC;
            S_MEMADDR: state_d = (Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: state_d = S_MEMWB;
            S_REXEC:   state_d = S_RWB;
            S_IEXEC:   state_d = S_IWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        PCSource  = PCSRC_ALU;
        InstrDone = 1'b0;
        IllegalOp = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB   = SRCB_IMM_SH;
                IllegalOp = ~legal;
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = 1'b1;
            end
            S_REXEC: ALUSrcA = 1'b1;
            S_RWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
            end
            S_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_IWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                PCSource  = PCSRC_ALUOUT;
                PCWrite   = take_branch;
                InstrDone = 1'b1;
            end
            S_JUMP: begin
                PCSource  = PCSRC_JUMP;
                PCWrite   = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed per-cycle checks of the control outputs
// for each instruction class, branch outcomes, illegal decodes and async reset.
module tb_mips_multicycle_control;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] Opcode = 6'h00;
    logic [5:0] Funct = 6'h00;
    logic       Zero = 1'b0;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUOperation;
    logic       InstrDone, IllegalOp;
    logic [18:0] obs;
    int checks = 0;
    int passed = 0;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOperation(ALUOperation), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                  ALUSrcA, ALUSrcB, PCSource, ALUOperation, InstrDone, IllegalOp};

    function automatic logic [18:0] pk(int pcw, int iord, int mr, int mw, int irw, int rd,
                                       int m2r, int rw, int asa, int asb, int pcs, int op,
                                       int done, int ill);
        return {1'(pcw), 1'(iord), 1'(mr), 1'(mw), 1'(irw), 1'(rd), 1'(m2r), 1'(rw),
                1'(asa), 2'(asb), 2'(pcs), 4'(op), 1'(done), 1'(ill)};
    endfunction

    // Masks keep each state's check to the fields the state actually defines.
    localparam logic [18:0] M_ALL  = '1;
    localparam logic [18:0] M_S    = pk(1,0,1,1,1,0,0,1,0,0,0,0,1,1);
    localparam logic [18:0] M_A    = pk(0,0,0,0,0,0,0,0,1,3,0,15,0,0);
    localparam logic [18:0] M_IORD = pk(0,1,0,0,0,0,0,0,0,0,0,0,0,0);
    localparam logic [18:0] M_WB   = pk(0,0,0,0,0,1,1,0,0,0,0,0,0,0);
    localparam logic [18:0] M_PCS  = pk(0,0,0,0,0,0,0,0,0,0,3,0,0,0);

    localparam logic [18:0] E_FETCH = pk(1,0,1,0,1,0,0,0,0,1,0,3,0,0);
    localparam logic [18:0] E_DEC   = pk(0,0,0,0,0,0,0,0,0,3,0,3,0,0);
    localparam logic [18:0] E_ILL   = pk(0,0,0,0,0,0,0,0,0,3,0,3,0,1);
    localparam logic [18:0] E_MADDR = pk(0,0,0,0,0,0,0,0,1,2,0,3,0,0);
    localparam logic [18:0] E_MREAD = pk(0,1,1,0,0,0,0,0,0,0,0,0,0,0);
    localparam logic [18:0] E_MWB   = pk(0,0,0,0,0,0,1,1,0,0,0,0,1,0);
    localparam logic [18:0] E_MWR   = pk(0,1,0,1,0,0,0,0,0,0,0,0,1,0);
    localparam logic [18:0] E_RWB   = pk(0,0,0,0,0,1,0,1,0,0,0,0,1,0);
    localparam logic [18:0] E_IWB   = pk(0,0,0,0,0,0,0,1,0,0,0,0,1,0);
    localparam logic [18:0] E_JUMP  = pk(1,0,0,0,0,0,0,0,0,0,2,0,1,0);
    localparam logic [18:0] E_RSUB  = pk(0,0,0,0,0,0,0,0,1,0,0,4,0,0);
    localparam logic [18:0] E_RSLL  = pk(0,0,0,0,0,0,0,0,1,0,0,14,0,0);
    localparam logic [18:0] E_IORI  = pk(0,0,0,0,0,0,0,0,1,2,0,1,0,0);
    localparam logic [18:0] E_BR_T  = pk(1,0,0,0,0,0,0,0,1,0,1,4,1,0);
    localparam logic [18:0] E_BR_N  = pk(0,0,0,0,0,0,0,0,1,0,1,4,1,0);

    task automatic chk(input string tag, input logic [18:0] e, input logic [18:0] m);
        #1;
        checks++;
        assert ((obs & m) === (e & m)) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs & m, e & m);
    endtask

    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    initial begin
        nxt; nxt;
        chk("reset_hold", E_FETCH, M_ALL);
        reset = 1'b1;
        // sub
        Opcode = 6'h00; Funct = 6'h22;
        chk("sub_fetch", E_FETCH, M_ALL);
        nxt; chk("sub_decode", E_DEC, M_S | M_A);
        nxt; chk("sub_rexec", E_RSUB, M_S | M_A);
        nxt; chk("sub_rwb", E_RWB, M_S | M_WB);
        nxt; chk("sub_back_fetch", E_FETCH, M_ALL);
        // lw
        Opcode = 6'h23;
        nxt; chk("lw_decode", E_DEC, M_S | M_A);
        nxt; chk("lw_memaddr", E_MADDR, M_S | M_A);
        nxt; chk("lw_memread", E_MREAD, M_S | M_IORD);
        nxt; chk("lw_memwb", E_MWB, M_S | M_WB);
        nxt; chk("lw_back_fetch", E_FETCH, M_ALL);
        // sw
        Opcode = 6'h2B;
        nxt; chk("sw_decode", E_DEC, M_S | M_A);
        nxt; chk("sw_memaddr", E_MADDR, M_S | M_A);
        nxt; chk("sw_memwrite", E_MWR, M_S | M_IORD);
        nxt; chk("sw_back_fetch", E_FETCH, M_ALL);
        // beq taken / not taken
        Opcode = 6'h04; Zero = 1'b0;
        nxt; chk("beq1_decode", E_DEC, M_S | M_A);
        Zero = 1'b1;
        nxt; chk("beq_taken", E_BR_T, M_S | M_A | M_PCS);
        Zero = 1'b0;
        nxt; chk("beq1_back_fetch", E_FETCH, M_ALL);
        nxt; chk("beq0_decode", E_DEC, M_S | M_A);
        nxt; chk("beq_not_taken", E_BR_N, M_S | M_A | M_PCS);
        // bne: inverse sense
        Opcode = 6'h05;
        nxt; chk("bne0_fetch", E_FETCH, M_ALL);
        nxt; chk("bne0_decode", E_DEC, M_S | M_A);
        nxt; chk("bne_taken", E_BR_T, M_S | M_A | M_PCS);
        nxt; Zero = 1'b1;
        nxt; chk("bne1_decode", E_DEC, M_S | M_A);
        nxt; chk("bne_not_taken", E_BR_N, M_S | M_A | M_PCS);
        Zero = 1'b0;
        // sll
        Opcode = 6'h00; Funct = 6'h00;
        nxt; chk("sll_fetch", E_FETCH, M_ALL);
        nxt; nxt; chk("sll_rexec", E_RSLL, M_S | M_A);
        nxt; chk("sll_rwb", E_RWB, M_S | M_WB);
        // ori
        Opcode = 6'h0D;
        nxt; nxt; chk("ori_decode", E_DEC, M_S | M_A);
        nxt; chk("ori_iexec", E_IORI, M_S | M_A);
        nxt; chk("ori_iwb", E_IWB, M_S | M_WB);
        // j
        Opcode = 6'h02;
        nxt; nxt; nxt; chk("j_jump", E_JUMP, M_S | M_PCS);
        nxt; chk("j_back_fetch", E_FETCH, M_ALL);
        // illegal opcode
        Opcode = 6'h3F;
        nxt; chk("ill_op_decode", E_ILL, M_S | M_A);
        nxt; chk("ill_op_fetch", E_FETCH, M_ALL);
        // illegal R-type funct
        Opcode = 6'h00; Funct = 6'h2A;
        nxt; chk("ill_fn_decode", E_ILL, M_S | M_A);
        nxt; chk("ill_fn_fetch", E_FETCH, M_ALL);
        // async reset mid-MEMREAD
        Opcode = 6'h23;
        nxt; nxt; nxt; chk("rst_pre_memread", E_MREAD, M_S | M_IORD);
        #1 reset = 1'b0;
        chk("rst_async_fetch", E_FETCH, M_ALL);
        nxt; chk("rst_held_fetch", E_FETCH, M_ALL);
        reset = 1'b1;
        chk("rst_release_fetch", E_FETCH, M_ALL);
        nxt; chk("rst_resume_decode", E_DEC, M_S | M_A);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
